// File: rtl/hs_pipeline_pkg.sv
// Shared types for the 4-phase handshake pipeline: per-stage FSM encodings and the
// width of the optional transfer counter.
package hs_pipeline_pkg;

   typedef enum logic {
      L_IDLE,
      L_ACK
   } l_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_REQ,
      R_RTZ
   } r_state_t;

   localparam int unsigned STATS_W = 16;

endpackage

// File: rtl/hs_pipeline_stage.sv
// One token slot of the elastic pipeline: a left 4-phase receiver FSM and a right
// 4-phase sender FSM sharing a single occupancy flag and data register.
module hs_stage
   import hs_pipeline_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             l_req,
   input  logic [WIDTH-1:0] l_data,
   output logic             l_ack,
   output logic             r_req,
   output logic [WIDTH-1:0] r_data,
   input  logic             r_ack,
   output logic             full
);

   l_state_t         l_state_q, l_state_d;
   r_state_t         r_state_q, r_state_d;
   logic             full_q, full_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             l_ack_q, l_ack_d;
   logic             r_req_q, r_req_d;

   always_comb begin
      l_state_d = l_state_q;
      r_state_d = r_state_q;
      full_d    = full_q;
      data_d    = data_q;
      l_ack_d   = l_ack_q;
      r_req_d   = r_req_q;

      // Capture needs full_q==0 and release needs full_q==1, so the two FSMs
      // never update full in the same edge.
      case (l_state_q)
         L_IDLE: if (l_req && !full_q) begin
            data_d    = l_data;
            full_d    = 1'b1;
            l_ack_d   = 1'b1;
            l_state_d = L_ACK;
         end
         L_ACK: if (!l_req) begin
            l_ack_d   = 1'b0;
            l_state_d = L_IDLE;
         end
         default: l_state_d = L_IDLE;
      endcase

      // A stale high ack from downstream holds back the next offer.
      case (r_state_q)
         R_IDLE: if (full_q && !r_ack) begin
            r_req_d   = 1'b1;
            r_state_d = R_REQ;
         end
         R_REQ: if (r_ack) begin
            r_req_d   = 1'b0;
            full_d    = 1'b0;
            r_state_d = R_RTZ;
         end
         R_RTZ: if (!r_ack) begin
            r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         l_state_q <= L_IDLE;
         r_state_q <= R_IDLE;
         full_q    <= 1'b0;
         data_q    <= '0;
         l_ack_q   <= 1'b0;
         r_req_q   <= 1'b0;
      end else begin
         l_state_q <= l_state_d;
         r_state_q <= r_state_d;
         full_q    <= full_d;
         data_q    <= data_d;
         l_ack_q   <= l_ack_d;
         r_req_q   <= r_req_d;
      end
   end

   assign l_ack  = l_ack_q;
   assign r_req  = r_req_q;
   assign r_data = data_q;
   assign full   = full_q;

endmodule

// File: rtl/hs_pipeline.sv
// DEPTH-stage 4-phase req/ack elastic pipeline of WIDTH-bit tokens.
// Define HS_PIPELINE_STATS_EN to add the xfer_cnt_o downstream transfer counter.
module hs_pipeline
   import hs_pipeline_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_i,
   input  logic [WIDTH-1:0]   data_i,
   output logic               ack_i,
   output logic               req_i1,
   output logic [WIDTH-1:0]   data_i1,
   input  logic               ack_i1,
   output logic [DEPTH-1:0]   full_o
`ifdef HS_PIPELINE_STATS_EN
   ,
   output logic [STATS_W-1:0] xfer_cnt_o
`endif
);

   // Link s is the left side of stage s; link DEPTH is the consumer port.
   logic [DEPTH:0]   req_w;
   logic [DEPTH:0]   ack_w;
   logic [WIDTH-1:0] data_w [DEPTH+1];

   assign req_w[0]     = req_i;
   assign data_w[0]    = data_i;
   assign ack_i        = ack_w[0];
   assign req_i1       = req_w[DEPTH];
   assign data_i1      = data_w[DEPTH];
   assign ack_w[DEPTH] = ack_i1;

   for (genvar s = 0; s < DEPTH; s++) begin : g_stage
      hs_stage #(
         .WIDTH(WIDTH)
      ) u_stage (
         .clk   (clk),
         .rst_n (rst_n),
         .l_req (req_w[s]),
         .l_data(data_w[s]),
         .l_ack (ack_w[s]),
         .r_req (req_w[s+1]),
         .r_data(data_w[s+1]),
         .r_ack (ack_w[s+1]),
         .full  (full_o[s])
      );
   end

`ifdef HS_PIPELINE_STATS_EN
   logic [STATS_W-1:0] xfer_cnt_q, xfer_cnt_d;

   // req_i1 is high exactly in the last stage's R_REQ, so this is the R_REQ->R_RTZ edge.
   always_comb begin
      xfer_cnt_d = xfer_cnt_q;
      if (req_i1 && ack_i1) begin
         xfer_cnt_d = xfer_cnt_q + STATS_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         xfer_cnt_q <= '0;
      end else begin
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

   assign xfer_cnt_o = xfer_cnt_q;
`endif

endmodule
